pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage ARM pipeline. Generates freeze and flush controls for the IF stage register and the PC, and a bubble-insert flush for the ID/EXE register. Its inputs are the hazard detection unit, the EXE-stage branch resolution and the MEM-stage SRAM handshake. It also tracks multi-cycle memory waits with a timeout and keeps saturating stall/flush performance counters.

Parameters:
BIT_NUMBER, 32, width of PC and branch target
CNT_WIDTH, 16, width of each performance counter
MEM_TIMEOUT, 64, number of MEM_WAIT cycles before mem_timeout is raised

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
hazard  in  1  RAW hazard from hazard unit; instruction in ID must stall one cycle
branch_taken  in  1  EXE resolved a taken branch
branch_addr  in  BIT_NUMBER  branch target from EXE
mem_req  in  1  MEM stage holds a load/store
mem_ready  in  1  SRAM completes the access this cycle
perf_clr  in  1  synchronous clear of both counters
freeze_all  out  1  freeze every stage register (memory stall)
freeze_if  out  1  freeze PC and IF stage register
flush_if  out  1  clear IF stage register (ignored by the register while frozen)
flush_id  out  1  load a bubble into ID/EXE register
pc_load  out  1  PC takes pc_target next edge
pc_target  out  BIT_NUMBER  redirect address
mem_timeout  out  1  sticky: a memory wait reached MEM_TIMEOUT
stall_cycles  out  CNT_WIDTH  cycles with freeze_if=1, saturating
flush_count  out  CNT_WIDTH  redirects issued, saturating

Behaviour:
- Reset: state=RUN, br_pend=0, br_target=0, wait_cnt=0, mem_timeout=0, both counters 0. All combinational outputs evaluate to 0 with idle inputs.
- States: RUN, MEM_WAIT.
- freeze_all = (RUN & mem_req & ~mem_ready) | (MEM_WAIT & ~mem_ready).
- RUN -> MEM_WAIT when mem_req & ~mem_ready; wait_cnt <= 1.
- MEM_WAIT -> RUN when mem_ready. In that cycle freeze_all=0 and the pipeline advances.
- MEM_WAIT with ~mem_ready: wait_cnt increments, saturating at MEM_TIMEOUT. When wait_cnt==MEM_TIMEOUT-1, mem_timeout <= 1 (sticky until rst). The state keeps waiting; there is no abort.
- Branch capture: if branch_taken & freeze_all & ~br_pend, then br_pend <= 1 and br_target <= branch_addr. A later branch_taken while br_pend=1 is ignored, since it is the same held EXE instruction.
- redirect = ~freeze_all & (br_pend | branch_taken), with one-cycle assertion:
  - pc_load=1, flush_if=1, flush_id=1.
  - pc_target = br_pend ? br_target : branch_addr; otherwise pc_target = 0.
  - br_pend <= 0.
- Hazard stall when hazard & ~freeze_all & ~redirect: freeze_if=1, flush_id=1, flush_if=0, pc_load=0. Latency is zero (combinational).
- Priority: memory freeze > branch redirect > hazard. A branch during a hazard flushes and discards the stall.
- freeze_if = freeze_all | hazard-stall term.
- Counters update on the edge:
  - stall_cycles += 1 when freeze_if=1.
  - flush_count += 1 when redirect=1.
  - Both saturate at all-ones.
  - perf_clr has priority over increment; the counter reads 0 next cycle.
- Reset mid-wait: all state returns to reset values immediately (async), and any pending branch is lost.
- mem_req & mem_ready in RUN is a single-cycle access: no freeze and no state change.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state encoding constants (RUN, MEM_WAIT) and the default MEM_TIMEOUT/CNT_WIDTH constants. The pipeline top also uses it.
- One sub-module: sat_counter (parameter WIDTH; inputs clk, rst, clr, inc; output count). Instantiate it twice for the performance counters.

Test Plan:
- Reset, idle inputs for 5 cycles -> all outputs 0, state RUN, counters 0.
- hazard=1 for 1 cycle -> same cycle freeze_if=1, flush_id=1, flush_if=0; next cycle stall_cycles=1, flush_count=0.
- branch_taken=1 with branch_addr=0x0000_0040 and hazard=1 -> pc_load=1, pc_target=0x40, flush_if=1, flush_id=1, freeze_if=0; flush_count=1.
- mem_req=1, mem_ready=0 for 3 cycles then 1; branch_taken=1 with addr 0x80 from the first cycle -> freeze_all=1 for 3 cycles with no pc_load. In the ready cycle pc_load=1, pc_target=0x80 and the redirect fires once; stall_cycles=3, flush_count=1.
- mem_req=1, mem_ready=0 held for MEM_TIMEOUT cycles -> mem_timeout rises after MEM_TIMEOUT-1 wait cycles and stays 1 after mem_ready returns. Async rst mid-wait -> freeze_all=0 and mem_timeout=0 immediately.
- Force stall_cycles to all-ones (CNT_WIDTH=4: 16 stall cycles) -> holds 15. perf_clr together with hazard -> next cycle reads 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall sequencer state encoding and default sizes.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam int unsigned DEF_BIT_NUMBER  = 32;
  localparam int unsigned DEF_CNT_WIDTH   = 16;
  localparam int unsigned DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, branch redirect,
// hazard bubble, memory-wait timeout and saturating performance counters.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BIT_NUMBER  = DEF_BIT_NUMBER,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard,
  input  logic                  branch_taken,
  input  logic [BIT_NUMBER-1:0] branch_addr,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  perf_clr,
  output logic                  freeze_all,
  output logic                  freeze_if,
  output logic                  flush_if,
  output logic                  flush_id,
  output logic                  pc_load,
  output logic [BIT_NUMBER-1:0] pc_target,
  output logic                  mem_timeout,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t           state, state_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_cnt_nxt;
  logic                  mem_timeout_nxt;
  logic                  br_pend, br_pend_nxt;
  logic [BIT_NUMBER-1:0] br_target, br_target_nxt;
  logic                  redirect;
  logic                  hazard_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      br_pend     <= 1'b0;
      br_target   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= mem_timeout_nxt;
      br_pend     <= br_pend_nxt;
      br_target   <= br_target_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    mem_timeout_nxt = mem_timeout;
    br_pend_nxt     = br_pend;
    br_target_nxt   = br_target;
    freeze_all      = 1'b0;
    redirect        = 1'b0;
    hazard_stall    = 1'b0;
    freeze_if       = 1'b0;
    flush_if        = 1'b0;
    flush_id        = 1'b0;
    pc_load         = 1'b0;
    pc_target       = '0;

    // Memory wait tracking; the ready cycle itself is never frozen.
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze_all   = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
        end else begin
          freeze_all = 1'b1;
          if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            mem_timeout_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase

    // A branch resolved while frozen is held until the freeze lifts.
    if (branch_taken && freeze_all && !br_pend) begin
      br_pend_nxt   = 1'b1;
      br_target_nxt = branch_addr;
    end

    redirect     = !freeze_all && (br_pend || branch_taken);
    hazard_stall = hazard && !freeze_all && !redirect;

    if (redirect) begin
      pc_load     = 1'b1;
      flush_if    = 1'b1;
      flush_id    = 1'b1;
      pc_target   = br_pend ? br_target : branch_addr;
      br_pend_nxt = 1'b0;
    end else if (hazard_stall) begin
      flush_id = 1'b1;
    end

    freeze_if = freeze_all || hazard_stall;
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (freeze_if),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (redirect),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: single-cycle vector table plus memory-wait,
// timeout, async-reset and counter-saturation sequences.
module tb_pipe_stall_ctrl;

  localparam int unsigned BN   = 32;
  localparam int unsigned CW   = 4;
  localparam int unsigned MTO  = 64;
  localparam int unsigned CMAX = (1 << CW) - 1;

  typedef struct {
    logic        hz;
    logic        bt;
    logic [31:0] ba;
    logic        mr;
    logic        mrdy;
    logic        clr;
    logic        fa;
    logic        fi;
    logic        fli;
    logic        fld;
    logic        pl;
    logic [31:0] pt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          hazard, branch_taken, mem_req, mem_ready, perf_clr;
  logic [BN-1:0] branch_addr;
  logic          freeze_all, freeze_if, flush_if, flush_id, pc_load, mem_timeout;
  logic [BN-1:0] pc_target;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic exp_to = 1'b0;
  vec_t vecs [8];

  pipe_stall_ctrl #(.BIT_NUMBER(BN), .CNT_WIDTH(CW), .MEM_TIMEOUT(MTO)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .perf_clr     (perf_clr),
    .freeze_all   (freeze_all),
    .freeze_if    (freeze_if),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the counter model.
  task automatic step(input string name, input vec_t v);
    hazard       = v.hz;
    branch_taken = v.bt;
    branch_addr  = v.ba;
    mem_req      = v.mr;
    mem_ready    = v.mrdy;
    perf_clr     = v.clr;
    @(negedge clk);
    check({name, ".freeze_all"}, 32'(freeze_all), 32'(v.fa));
    check({name, ".freeze_if"},  32'(freeze_if),  32'(v.fi));
    check({name, ".flush_if"},   32'(flush_if),   32'(v.fli));
    check({name, ".flush_id"},   32'(flush_id),   32'(v.fld));
    check({name, ".pc_load"},    32'(pc_load),    32'(v.pl));
    check({name, ".pc_target"},  pc_target,       v.pt);
    check({name, ".mem_timeout"}, 32'(mem_timeout), 32'(exp_to));
    check({name, ".stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    check({name, ".flush_count"},  32'(flush_count),  32'(exp_flush));
    @(posedge clk);
    if (v.clr) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (v.fi && exp_stall < int'(CMAX)) exp_stall++;
      if (v.pl && exp_flush < int'(CMAX)) exp_flush++;
    end
    #1;
  endtask

  function automatic vec_t mk(input logic hz, input logic bt, input logic [31:0] ba,
                              input logic mr, input logic mrdy, input logic clr,
                              input logic fa, input logic fi, input logic fli,
                              input logic fld, input logic pl, input logic [31:0] pt);
    vec_t v;
    v.hz = hz; v.bt = bt; v.ba = ba; v.mr = mr; v.mrdy = mrdy; v.clr = clr;
    v.fa = fa; v.fi = fi; v.fli = fli; v.fld = fld; v.pl = pl; v.pt = pt;
    return v;
  endfunction

  initial begin
    vec_t idle;
    idle = mk(0,0,0, 0,0,0, 0,0,0,0,0,0);

    //          hz bt addr          mr rdy clr  fa fi fli fld pl target
    vecs[0] = mk(0, 0, 32'h0,        0, 0, 0,   0, 0, 0, 0, 0, 32'h0);
    vecs[1] = mk(1, 0, 32'h0,        0, 0, 0,   0, 1, 0, 1, 0, 32'h0);
    vecs[2] = mk(1, 1, 32'h40,       0, 0, 0,   0, 0, 1, 1, 1, 32'h40);
    vecs[3] = mk(0, 1, 32'h1234,     0, 0, 0,   0, 0, 1, 1, 1, 32'h1234);
    vecs[4] = mk(0, 0, 32'hdead,     1, 1, 0,   0, 0, 0, 0, 0, 32'h0);
    vecs[5] = mk(1, 0, 32'h0,        1, 1, 0,   0, 1, 0, 1, 0, 32'h0);
    vecs[6] = mk(0, 1, 32'h88,       1, 1, 0,   0, 0, 1, 1, 1, 32'h88);
    vecs[7] = mk(0, 0, 32'hffff_fff0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0);

    rst = 1'b1;
    hazard = 0; branch_taken = 0; branch_addr = '0;
    mem_req = 0; mem_ready = 0; perf_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) step("reset_idle", idle);

    for (int i = 0; i < 8; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Memory wait with a branch arriving on the first frozen cycle; later addr must be ignored.
    step("memwait0", mk(0,1,32'h80, 1,0,0, 1,1,0,0,0,0));
    step("memwait1", mk(0,1,32'hff, 1,0,0, 1,1,0,0,0,0));
    step("memwait2", mk(1,1,32'hff, 1,0,0, 1,1,0,0,0,0));
    step("memready", mk(1,1,32'hff, 1,1,0, 0,0,1,1,1,32'h80));
    step("after_redirect", idle);
    check("memwait.stall_total", 32'(stall_cycles), 32'(2 + 3));
    check("memwait.flush_total", 32'(flush_count), 32'(3 + 1));

    // Timeout: held wait raises mem_timeout after MTO cycles of not-ready, and it sticks.
    for (int i = 0; i < int'(MTO); i++) step($sformatf("to_wait%0d", i), mk(0,0,0, 1,0,0, 1,1,0,0,0,0));
    exp_to = 1'b1;
    step("to_ready", mk(0,0,0, 1,1,0, 0,0,0,0,0,0));
    step("to_sticky", idle);

    // Async reset in the middle of a wait with a branch pending.
    step("rst_wait0", mk(0,1,32'h44, 1,0,0, 1,1,0,0,0,0));
    step("rst_wait1", mk(0,0,32'h0,  1,0,0, 1,1,0,0,0,0));
    mem_req = 0; branch_taken = 0;
    rst = 1'b1;
    #1;
    check("async_rst.freeze_all", 32'(freeze_all), 32'(0));
    check("async_rst.mem_timeout", 32'(mem_timeout), 32'(0));
    check("async_rst.stall_cycles", 32'(stall_cycles), 32'(0));
    check("async_rst.pc_load", 32'(pc_load), 32'(0));
    exp_to = 1'b0; exp_stall = 0; exp_flush = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    step("post_rst_no_redirect", idle);

    // Stall counter saturation and clear priority over increment.
    for (int i = 0; i < 16; i++) step($sformatf("sat%0d", i), mk(1,0,0, 0,0,0, 0,1,0,1,0,0));
    check("sat.stall_cycles", 32'(stall_cycles), 32'(CMAX));
    step("sat_hold", mk(1,0,0, 0,0,0, 0,1,0,1,0,0));
    step("clr_with_hazard", mk(1,0,0, 0,0,1, 0,1,0,1,0,0));
    step("after_clr", idle);
    check("clr.stall_cycles", 32'(stall_cycles), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
